word_reader_b: RTL

// Downstream consumer of the template list stage for plain (non-template) word lists. Reads the

---
 rtl/word_reader_b.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/word_reader_b.sv
`default_nettype none
// ============================================================================
// Module   : word_reader_b
// Purpose  : Reads one plain word out of the 8-bit word storage, drops the
//            '\0' terminator and padding, and streams the characters as a
//            valid/ready byte stream tagged with word_id and last/zero-length/
//            list-end flags. Releases the storage (st_set_empty) right after
//            the final storage read so the list stage can refill while the
//            buffered bytes drain.
// Ports    : CLK, reset_n (async, active low)
//            st_dout / st_rd_addr / st_empty / st_set_empty : storage side
//            word_id_in / word_list_end_in                  : stored word tags
//            dout / dout_valid / dout_ready / dout_last /
//            dout_zero_len / dout_list_end / word_id        : output stream
// Revision : 1.0 - initial release
// ============================================================================
module word_reader_b #(
    parameter  int WORD_MAX_LEN = 8,
    localparam int ADDR_W       = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic [7:0]        st_dout,
    output logic [ADDR_W-1:0] st_rd_addr,
    input  logic              st_empty,
    output logic              st_set_empty,
    input  logic [15:0]       word_id_in,
    input  logic              word_list_end_in,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              dout_zero_len,
    output logic              dout_list_end,
    output logic [15:0]       word_id
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORD_MAX_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_READ     = 3'd2,
        S_RELEASE  = 3'd3,
        S_DRAIN    = 3'd4,
        S_END_BEAT = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_all_issued;     // index WORD_MAX_LEN-1 already requested
    logic              r_rd_vld;         // st_dout carries a requested byte this cycle
    logic [ADDR_W-1:0] r_rd_idx;         // index of that byte
    logic [7:0]        r_pend;           // byte waiting for its successor
    logic              r_pend_final;     // r_pend is the last byte of a full-length word
    logic [15:0]       r_word_id;
    logic              r_list_end;
    logic              r_end_pulsed;

    // Skid buffer entries: {zero_len, last, data}
    logic [9:0]        r_buf [2];
    logic              r_wptr, r_rptr;
    logic [1:0]        r_count;

    logic              w_issue, w_push, w_pop, w_term;
    logic              w_pend_load, w_pend_final_set, w_pend_final_clr;
    logic [9:0]        w_push_entry;
    logic [2:0]        w_fill;
    logic [9:0]        w_head;

    assign w_pop  = (r_count != 2'd0) && dout_ready;
    assign w_head = r_buf[r_rptr];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_all_issued <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_rd_idx     <= '0;
            r_pend       <= 8'd0;
            r_pend_final <= 1'b0;
            r_word_id    <= 16'd0;
            r_list_end   <= 1'b0;
            r_end_pulsed <= 1'b0;
            r_buf[0]     <= 10'd0;
            r_buf[1]     <= 10'd0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_issue) begin
                r_rd_vld <= 1'b1;
                r_rd_idx <= r_addr;
                // Saturate at the last index so the address never wraps.
                if (r_addr == LAST_IDX) begin
                    r_all_issued <= 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end else begin
                r_rd_vld <= 1'b0;
            end

            if (w_state_nxt == S_IDLE) begin
                r_addr       <= '0;
                r_all_issued <= 1'b0;
            end

            if (r_state == S_IDLE && w_state_nxt == S_START) begin
                r_word_id  <= word_id_in;
                r_list_end <= word_list_end_in;
            end

            if (w_pend_load) begin
                r_pend <= st_dout;
            end
            if (w_pend_final_set) begin
                r_pend_final <= 1'b1;
            end else if (w_pend_final_clr) begin
                r_pend_final <= 1'b0;
            end

            r_end_pulsed <= (r_state == S_END_BEAT);

            if (w_push) begin
                r_buf[r_wptr] <= w_push_entry;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_issue          = 1'b0;
        w_push           = 1'b0;
        w_push_entry     = 10'd0;
        w_pend_load      = 1'b0;
        w_pend_final_set = 1'b0;
        w_pend_final_clr = 1'b0;
        w_term           = 1'b0;
        w_fill           = 3'd0;

        case (r_state)
            S_IDLE: begin
                // Address is 0 here, so byte 0 is requested in the same cycle
                // the word is seen; this keeps first-beat latency at 3 cycles.
                if (!st_empty) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_START;
                end
            end

            S_START, S_READ: begin
                if (r_state == S_START && r_list_end) begin
                    w_state_nxt = S_END_BEAT;
                end else begin
                    w_state_nxt = S_READ;
                    if (r_rd_vld) begin
                        if (r_rd_idx == '0) begin
                            if (st_dout == 8'd0) begin
                                w_push       = 1'b1;
                                w_push_entry = {1'b1, 1'b1, 8'd0};
                                w_term       = 1'b1;
                            end else if (r_rd_idx == LAST_IDX) begin
                                w_push       = 1'b1;
                                w_push_entry = {1'b0, 1'b1, st_dout};
                                w_term       = 1'b1;
                            end else begin
                                w_pend_load  = 1'b1;
                            end
                        end else if (st_dout == 8'd0) begin
                            w_push       = 1'b1;
                            w_push_entry = {1'b0, 1'b1, r_pend};
                            w_term       = 1'b1;
                        end else begin
                            // Successor is a real character: the held byte is
                            // not last. A full-length final byte is pushed later.
                            w_push       = 1'b1;
                            w_push_entry = {1'b0, 1'b0, r_pend};
                            w_pend_load  = 1'b1;
                            if (r_rd_idx == LAST_IDX) begin
                                w_pend_final_set = 1'b1;
                                w_term           = 1'b1;
                            end
                        end
                    end
                    // Request another byte only if the buffer is guaranteed a
                    // free slot when that byte returns next cycle.
                    w_fill = {1'b0, r_count} + {2'b00, w_push} - {2'b00, w_pop};
                    if (w_term) begin
                        w_state_nxt = S_RELEASE;
                    end else if (!r_all_issued && (w_fill <= 3'd1)) begin
                        w_issue = 1'b1;
                    end
                end
            end

            S_RELEASE, S_DRAIN: begin
                if (r_pend_final && ((r_count != 2'd2) || w_pop)) begin
                    w_push           = 1'b1;
                    w_push_entry     = {1'b0, 1'b1, r_pend};
                    w_pend_final_clr = 1'b1;
                end
                if (r_state == S_RELEASE) begin
                    w_state_nxt = S_DRAIN;
                end else if (r_count == 2'd0 && !r_pend_final) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_END_BEAT: begin
                if (dout_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign st_rd_addr    = r_addr;
    assign st_set_empty  = (r_state == S_RELEASE) || (r_state == S_END_BEAT && !r_end_pulsed);
    assign dout_list_end = (r_state == S_END_BEAT);
    assign dout_valid    = dout_list_end || (r_count != 2'd0);
    assign dout          = (r_count != 2'd0) ? w_head[7:0] : 8'd0;
    assign dout_last     = dout_list_end || ((r_count != 2'd0) && w_head[8]);
    assign dout_zero_len = (r_count != 2'd0) && w_head[9];
    assign word_id       = r_word_id;

endmodule
`default_nettype wire
